// File: rtl/iob_cache_perf_ctrl_pkg.sv
// Shared definitions for the cache perf/control block: register map, CTRL/STATUS bit
// positions, event indices and the invalidate FSM state type.
package iob_cache_perf_ctrl_pkg;

    localparam int unsigned ADDR_CTRL       = 0;
    localparam int unsigned ADDR_STATUS     = 1;
    localparam int unsigned ADDR_VERSION    = 2;
    localparam int unsigned ADDR_CH_SEL     = 3;
    localparam int unsigned ADDR_READ_HIT   = 4;
    localparam int unsigned ADDR_READ_MISS  = 5;
    localparam int unsigned ADDR_WRITE_HIT  = 6;
    localparam int unsigned ADDR_WRITE_MISS = 7;
    localparam int unsigned ADDR_HIT_TOTAL  = 8;
    localparam int unsigned ADDR_MISS_TOTAL = 9;

    localparam int unsigned CTRL_INVALIDATE = 0;
    localparam int unsigned CTRL_CLEAR      = 1;
    localparam int unsigned CTRL_FREEZE     = 2;

    localparam int unsigned STATUS_WTBUF_EMPTY = 0;
    localparam int unsigned STATUS_WTBUF_FULL  = 1;
    localparam int unsigned STATUS_INV_BUSY    = 2;

    localparam logic [15:0] DEFAULT_VERSION = 16'h0100;

    localparam int unsigned N_EV        = 4;
    localparam int unsigned EV_RD_HIT   = 0;
    localparam int unsigned EV_RD_MISS  = 1;
    localparam int unsigned EV_WR_HIT   = 2;
    localparam int unsigned EV_WR_MISS  = 3;

    typedef enum logic {StIdle, StBusy} inv_state_e;

endpackage

// File: rtl/iob_cache_sat_cnt.sv
// Saturating up-counter; a clear in the same cycle as an enable wins.
module iob_cache_sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/iob_cache_perf_ctrl.sv
// Cache control/perf-monitor register block: per-channel hit/miss counters, freeze/clear,
// channel select, handshaked invalidate request and status/version readback.
module iob_cache_perf_ctrl
    import iob_cache_perf_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned N_CH    = 2,
    parameter int unsigned ADDR_W  = 4,
    parameter logic [15:0] VERSION = DEFAULT_VERSION
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wen_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ready_o,
    input  logic [N_CH-1:0]   read_hit_i,
    input  logic [N_CH-1:0]   read_miss_i,
    input  logic [N_CH-1:0]   write_hit_i,
    input  logic [N_CH-1:0]   write_miss_i,
    input  logic              wtbuf_empty_i,
    input  logic              wtbuf_full_i,
    output logic              invalidate_o,
    input  logic              invalidate_done_i
);

    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [SEL_W-1:0]  ch_sel_q, ch_sel_d;
    logic              freeze_q;
    logic [DATA_W-1:0] rdata_q, rd_mux;
    logic              ready_q;
    inv_state_e        state_q, state_d;

    logic [N_CH-1:0]   ev [N_EV];
    logic [CNT_W-1:0]  cnt [N_EV][N_CH];
    logic [CNT_W:0]    hit_sum, miss_sum;
    logic [CNT_W-1:0]  hit_tot, miss_tot;

    logic wr, ctrl_wr, clr;

    assign wr      = valid_i && wen_i;
    assign ctrl_wr = wr && (addr_i == ADDR_W'(ADDR_CTRL));
    assign clr     = ctrl_wr && wdata_i[CTRL_CLEAR];

    assign ev[EV_RD_HIT]  = read_hit_i;
    assign ev[EV_RD_MISS] = read_miss_i;
    assign ev[EV_WR_HIT]  = write_hit_i;
    assign ev[EV_WR_MISS] = write_miss_i;

    for (genvar e = 0; e < N_EV; e++) begin : g_ev
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            iob_cache_sat_cnt #(.W(CNT_W)) u_cnt (
                .clk_i    (clk_i),
                .arst_n_i (arst_n_i),
                .en       (ev[e][c] && !freeze_q),
                .clr      (clr),
                .cnt      (cnt[e][c])
            );
        end
    end

    // Out-of-range selects clamp to the last channel so the read mux never indexes past N_CH.
    always_comb begin
        ch_sel_d = ch_sel_q;
        if (wr && (addr_i == ADDR_W'(ADDR_CH_SEL))) begin
            if (wdata_i >= DATA_W'(N_CH)) ch_sel_d = SEL_W'(N_CH - 1);
            else                          ch_sel_d = wdata_i[SEL_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (ctrl_wr && wdata_i[CTRL_INVALIDATE]) state_d = StBusy;
            StBusy:  if (invalidate_done_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign invalidate_o = (state_q == StBusy);

    assign hit_sum  = {1'b0, cnt[EV_RD_HIT][ch_sel_q]} + {1'b0, cnt[EV_WR_HIT][ch_sel_q]};
    assign miss_sum = {1'b0, cnt[EV_RD_MISS][ch_sel_q]} + {1'b0, cnt[EV_WR_MISS][ch_sel_q]};
    assign hit_tot  = hit_sum[CNT_W] ? {CNT_W{1'b1}} : hit_sum[CNT_W-1:0];
    assign miss_tot = miss_sum[CNT_W] ? {CNT_W{1'b1}} : miss_sum[CNT_W-1:0];

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            ADDR_W'(ADDR_CTRL):       rd_mux[CTRL_FREEZE] = freeze_q;
            ADDR_W'(ADDR_STATUS): begin
                rd_mux[STATUS_WTBUF_EMPTY] = wtbuf_empty_i;
                rd_mux[STATUS_WTBUF_FULL]  = wtbuf_full_i;
                rd_mux[STATUS_INV_BUSY]    = invalidate_o;
            end
            ADDR_W'(ADDR_VERSION):    rd_mux = DATA_W'(VERSION);
            ADDR_W'(ADDR_CH_SEL):     rd_mux = DATA_W'(ch_sel_q);
            ADDR_W'(ADDR_READ_HIT):   rd_mux = DATA_W'(cnt[EV_RD_HIT][ch_sel_q]);
            ADDR_W'(ADDR_READ_MISS):  rd_mux = DATA_W'(cnt[EV_RD_MISS][ch_sel_q]);
            ADDR_W'(ADDR_WRITE_HIT):  rd_mux = DATA_W'(cnt[EV_WR_HIT][ch_sel_q]);
            ADDR_W'(ADDR_WRITE_MISS): rd_mux = DATA_W'(cnt[EV_WR_MISS][ch_sel_q]);
            ADDR_W'(ADDR_HIT_TOTAL):  rd_mux = DATA_W'(hit_tot);
            ADDR_W'(ADDR_MISS_TOTAL): rd_mux = DATA_W'(miss_tot);
            default:                  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ch_sel_q <= '0;
            freeze_q <= 1'b0;
            state_q  <= StIdle;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ch_sel_q <= ch_sel_d;
            state_q  <= state_d;
            ready_q  <= valid_i;
            rdata_q  <= (valid_i && !wen_i) ? rd_mux : '0;
            if (ctrl_wr) freeze_q <= wdata_i[CTRL_FREEZE];
        end
    end

    assign ready_o = ready_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_iob_cache_perf_ctrl.sv
// Scoreboard bench for iob_cache_perf_ctrl: requests push expected responses, a monitor
// pops and compares them when ready_o is seen.
module tb_iob_cache_perf_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned N_CH   = 3;
    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic [N_CH-1:0]   rh, rm, wh, wm;
    logic              wt_empty, wt_full;
    logic              inv;
    logic              inv_done;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iob_cache_perf_ctrl #(
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W),
        .N_CH    (N_CH),
        .ADDR_W  (ADDR_W),
        .VERSION (16'h0100)
    ) dut (
        .clk_i             (clk),
        .arst_n_i          (arst_n),
        .valid_i           (valid),
        .addr_i            (addr),
        .wen_i             (wen),
        .wdata_i           (wdata),
        .rdata_o           (rdata),
        .ready_o           (ready),
        .read_hit_i        (rh),
        .read_miss_i       (rm),
        .write_hit_i       (wh),
        .write_miss_i      (wm),
        .wtbuf_empty_i     (wt_empty),
        .wtbuf_full_i      (wt_full),
        .invalidate_o      (inv),
        .invalidate_done_i (inv_done)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_ready: got ready=1 at cycle %0d expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e.data || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL %s: got rdata=%0h at cycle %0d expected %0h at cycle %0d",
                                 e.nm, rdata, cyc, e.data, e.cyc);
                    end
                end
            end else if (rdata !== '0) begin
                n_err++;
                $display("FAIL rdata_idle: got %0h expected 0 while ready=0", rdata);
            end
        end
    endtask

    task automatic cyc_start();
        @(posedge clk);
        #1;
        valid = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
        rh = '0; rm = '0; wh = '0; wm = '0; inv_done = 1'b0;
    endtask

    task automatic req(input logic w, input int a, input logic [31:0] d,
                       input logic [31:0] e, input string nm);
        cyc_start();
        valid = 1'b1; wen = w; addr = ADDR_W'(a); wdata = d;
        exp_q.push_back('{data: e, cyc: cyc + 1, nm: nm});
    endtask

    task automatic wr(input int a, input logic [31:0] d, input string nm);
        req(1'b1, a, d, 32'h0, nm);
    endtask

    task automatic rd(input int a, input logic [31:0] e, input string nm);
        req(1'b0, a, 32'h0, e, nm);
    endtask

    task automatic strobe(input logic [N_CH-1:0] a, input logic [N_CH-1:0] b,
                          input logic [N_CH-1:0] c, input logic [N_CH-1:0] d);
        cyc_start();
        rh = a; rm = b; wh = c; wm = d;
    endtask

    initial begin
        arst_n = 1'b0; valid = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
        rh = '0; rm = '0; wh = '0; wm = '0; inv_done = 1'b0;
        wt_empty = 1'b1; wt_full = 1'b0;
        fork
            monitor();
        join_none
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_inv", {31'h0, inv}, 32'h0);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;

        rd(2, 32'h0100, "version");
        for (int a = 4; a <= 9; a++) rd(a, 32'h0, "cnt_reset");
        rd(0, 32'h0, "ctrl_reset");
        rd(1, 32'h1, "status_reset");
        cyc_start();

        // ch1: 5 read hits (one paired with a write hit); ch0: 3 write misses
        strobe(3'b010, 3'b000, 3'b000, 3'b001);
        strobe(3'b010, 3'b000, 3'b000, 3'b000);
        strobe(3'b010, 3'b000, 3'b010, 3'b001);
        strobe(3'b010, 3'b000, 3'b000, 3'b000);
        strobe(3'b010, 3'b000, 3'b000, 3'b001);
        wr(3, 32'h1, "wr_chsel1");
        rd(3, 32'h1, "chsel_rb");
        rd(4, 32'd5, "ch1_read_hit");
        rd(6, 32'd1, "ch1_write_hit");
        rd(8, 32'd6, "ch1_hit_total");
        rd(5, 32'd0, "ch1_read_miss");
        rd(9, 32'd0, "ch1_miss_total");
        wr(3, 32'h0, "wr_chsel0");
        rd(7, 32'd3, "ch0_write_miss");
        rd(4, 32'd0, "ch0_read_hit");
        rd(9, 32'd3, "ch0_miss_total");
        wr(3, 32'h7, "wr_chsel7");
        rd(3, 32'h2, "chsel_clamp7");
        wr(3, 32'h3, "wr_chsel3");
        rd(3, 32'h2, "chsel_clamp3");
        wr(3, 32'h0, "wr_chsel0b");

        // saturation: 20 read misses, 13 more write misses on ch0
        for (int i = 0; i < 20; i++) strobe(3'b000, 3'b001, 3'b000, (i < 13) ? 3'b001 : 3'b000);
        rd(5, 32'd15, "sat_read_miss");
        rd(7, 32'd15, "sat_write_miss");
        rd(9, 32'd15, "sat_miss_total");
        rd(8, 32'd0, "ch0_hit_total");

        // clear with simultaneous strobes: clear wins
        wr(0, 32'h2, "wr_clear");
        rm = 3'b111; wh = 3'b111;
        rd(5, 32'd0, "clr_read_miss");
        rd(7, 32'd0, "clr_write_miss");
        rd(6, 32'd0, "clr_write_hit0");
        wr(3, 32'h1, "wr_chsel1b");
        rd(4, 32'd0, "clr_read_hit1");
        rd(6, 32'd0, "clr_write_hit1");
        rd(0, 32'h0, "ctrl_after_clr");

        wr(0, 32'h4, "wr_freeze");
        rd(0, 32'h4, "ctrl_freeze");
        for (int i = 0; i < 10; i++) strobe(3'b010, 3'b000, 3'b000, 3'b010);
        rd(4, 32'd0, "frz_read_hit");
        rd(7, 32'd0, "frz_write_miss");
        wr(0, 32'h0, "wr_unfreeze");
        strobe(3'b010, 3'b000, 3'b000, 3'b000);
        rd(4, 32'd1, "unfrz_read_hit");
        rd(8, 32'd1, "unfrz_hit_total");
        rd(0, 32'h0, "ctrl_unfrozen");

        wr(0, 32'h1, "wr_inv");
        check("inv_req_cycle", {31'h0, inv}, 32'h0);
        cyc_start();
        check("inv_rise", {31'h0, inv}, 32'h1);
        rd(1, 32'h5, "status_busy");
        wr(0, 32'h5, "wr_inv_busy");
        rd(0, 32'h4, "ctrl_freeze_while_busy");
        rd(1, 32'h5, "status_still_busy");
        cyc_start();
        inv_done = 1'b1;
        check("inv_at_done", {31'h0, inv}, 32'h1);
        cyc_start();
        check("inv_fall", {31'h0, inv}, 32'h0);
        rd(1, 32'h1, "status_idle");
        cyc_start();
        inv_done = 1'b1;
        cyc_start();
        check("done_idle_ignored", {31'h0, inv}, 32'h0);
        wr(0, 32'h0, "wr_ctrl0");

        wr(0, 32'h1, "wr_inv2");
        repeat (2) cyc_start();
        check("inv2_busy", {31'h0, inv}, 32'h1);
        cyc_start();
        #2 arst_n = 1'b0;
        #1;
        check("rst_drop_inv", {31'h0, inv}, 32'h0);
        check("rst_drop_ready", {31'h0, ready}, 32'h0);
        repeat (2) cyc_start();
        arst_n = 1'b1;

        wt_full = 1'b1; wt_empty = 1'b0;
        rd(1, 32'h2, "status_full");
        rd(0, 32'h0, "ctrl_post_rst");
        rd(3, 32'h0, "chsel_post_rst");
        wr(3, 32'h1, "wr_chsel1c");
        rd(4, 32'd0, "cnt_post_rst");
        rd(12, 32'h0, "unmapped_rd");
        wr(15, 32'hffff_ffff, "unmapped_wr");
        wr(2, 32'h0000_dead, "wr_version");
        rd(2, 32'h0100, "version_ro");
        wr(1, 32'h7, "wr_status");
        rd(1, 32'h2, "status_ro");
        repeat (3) cyc_start();
        check("queue_drained", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
